// File: rtl/if_id_skid_reg_pkg.sv
// Shared definitions for the IF->ID skid register: control levels, NOP default
// and the 2-entry skid buffer state encoding.
package if_id_skid_reg_pkg;

    localparam logic        ENABLE           = 1'b1;
    localparam logic        DISABLE          = 1'b0;
    localparam logic [31:0] ZERO             = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    // State encoding doubles as the entry count.
    function automatic logic [1:0] occupancy(input skid_state_t s);
        return logic'(1'b0) ? 2'd0 : s;
    endfunction

endpackage

// File: rtl/if_id_skid_reg_skid_buf.sv
// Generic WIDTH-bit 2-entry skid buffer with flush. The main register drives the
// output; the skid register absorbs one entry while the consumer stalls.
module skid_buf_2e
    import if_id_skid_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data,
    output skid_state_t      state
);

    skid_state_t      state_nxt;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             up_xfer;
    logic             dn_xfer;
    logic             load_main_up;
    logic             load_main_skid;
    logic             load_skid;

    // Both handshake flags decode only the registered state, so dn_ready never
    // reaches up_ready combinationally.
    assign up_ready = (state != ST_FULL);
    assign dn_valid = (state != ST_EMPTY);
    assign dn_data  = main_data;
    assign up_xfer  = up_valid & up_ready;
    assign dn_xfer  = dn_valid & dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_up   = DISABLE;
        load_main_skid = DISABLE;
        load_skid      = DISABLE;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        state_nxt    = ST_ONE;
                        load_main_up = ENABLE;
                    end
                end
                ST_ONE: begin
                    if (up_xfer && dn_xfer) begin
                        load_main_up = ENABLE;
                    end else if (up_xfer) begin
                        state_nxt = ST_FULL;
                        load_skid = ENABLE;
                    end else if (dn_xfer) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (dn_xfer) begin
                        state_nxt      = ST_ONE;
                        load_main_skid = ENABLE;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= '0;
            skid_data <= '0;
        end else begin
            if (load_main_up) begin
                main_data <= up_data;
            end else if (load_main_skid) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with valid/ready handshake, flush and a 2-entry skid
// buffer; bubbles present NOP_INST to the decoder.
module if_id_skid_reg
    import if_id_skid_reg_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEFAULT)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [PC_W-1:0]   up_pc_i,
    input  logic [INST_W-1:0] up_inst_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [PC_W-1:0]   dn_pc_o,
    output logic [INST_W-1:0] dn_inst_o,
    output logic [1:0]        occ_o
);

    localparam int unsigned WIDTH = PC_W + INST_W;

    logic [WIDTH-1:0] dn_data;
    skid_state_t      state;

    skid_buf_2e #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .flush    (flush_i),
        .up_valid (up_valid_i),
        .up_ready (up_ready_o),
        .up_data  ({up_pc_i, up_inst_i}),
        .dn_valid (dn_valid_o),
        .dn_ready (dn_ready_i),
        .dn_data  (dn_data),
        .state    (state)
    );

    assign dn_pc_o   = dn_data[WIDTH-1:INST_W];
    assign dn_inst_o = dn_valid_o ? dn_data[INST_W-1:0] : NOP_INST;
    assign occ_o     = occupancy(state);

endmodule
